// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8N1 UART receiver sampling RxD at OVERSAMPLE x baud,
// with 2-of-3 mid-bit voting. Define UART_RX_PARITY_EN for one even-parity bit.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   RxD               asynchronous serial input, idles high
//   RxD_data          last good byte, LSB received first
//   RxD_data_ready    1-cycle pulse when RxD_data updates
//   RxD_frame_error   1-cycle pulse when the stop bit votes low
//   RxD_parity_error  1-cycle pulse alongside ready on parity mismatch
//   RxD_idle          high while waiting for a start bit
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_error,
    output logic       RxD_parity_error,
    output logic       RxD_idle
);

    localparam int DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [TW-1:0] T_WRAP = TW'(DIV - 1);
    localparam logic [SW-1:0] S_V0   = SW'(M - 1);
    localparam logic [SW-1:0] S_V1   = SW'(M);
    localparam logic [SW-1:0] S_VOTE = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rxs_q, rxs_prev_q;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          v0_q, v0_d, v1_q, v1_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          ferr_q, ferr_d;
    logic          fall, start_det, tick, at_vote, at_end, vote;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          perr_q, perr_d;
`endif

    assign fall      = rxs_prev_q & ~rxs_q;
    assign start_det = (state_q == ST_IDLE) && fall;
    assign tick      = (tcnt_q == T_WRAP);
    assign at_vote   = tick && (scnt_q == S_VOTE);
    assign at_end    = tick && (scnt_q == S_LAST);
    // Third sample is the live value at the vote tick.
    assign vote      = (v0_q & v1_q) | (v0_q & rxs_q) | (v1_q & rxs_q);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (fall) state_d = ST_START;
            ST_START: begin
                if (at_vote && vote) state_d = ST_IDLE;
                else if (at_end)     state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at_end && bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
            ST_PARITY: if (at_end) state_d = ST_STOP;
            // Leaving at mid-stop lets a new start bit be caught early.
            ST_STOP:   if (at_vote) state_d = vote ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rxs_q) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready_d  = 1'b0;
        ferr_d   = 1'b0;
        RxD_idle = (state_q == ST_IDLE);
        if (state_q == ST_STOP && at_vote) begin
            ready_d = vote;
            ferr_d  = !vote;
        end
`ifdef UART_RX_PARITY_EN
        perr_d = ready_d & par_bad_q;
`endif
    end

    // Datapath next state
    always_comb begin
        tcnt_d  = (tick || start_det) ? '0 : tcnt_q + TW'(1);
        scnt_d  = scnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        data_d  = data_q;
        if (start_det) begin
            scnt_d = '0;
        end else if (tick && state_q != ST_IDLE) begin
            scnt_d = (scnt_q == S_LAST) ? '0 : scnt_q + SW'(1);
        end
        if (tick && scnt_q == S_V0) v0_d = rxs_q;
        if (tick && scnt_q == S_V1) v1_d = rxs_q;
        if (state_q == ST_START && at_end) bidx_d = '0;
        if (state_q == ST_DATA) begin
            if (at_vote) shreg_d = {vote, shreg_q[7:1]};
            if (at_end)  bidx_d  = bidx_q + 3'd1;
        end
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        if (state_q == ST_PARITY && at_vote) par_bad_d = vote ^ (^shreg_q);
`endif
        if (ready_d) data_d = shreg_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            tcnt_q     <= '0;
            scnt_q     <= '0;
            bidx_q     <= '0;
            shreg_q    <= '0;
            v0_q       <= 1'b1;
            v1_q       <= 1'b1;
            data_q     <= '0;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= RxD;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            tcnt_q     <= tcnt_d;
            scnt_q     <= scnt_d;
            bidx_q     <= bidx_d;
            shreg_q    <= shreg_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign RxD_data        = data_q;
    assign RxD_data_ready  = ready_q;
    assign RxD_frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign RxD_parity_error = perr_q;
`else
    assign RxD_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: drives serial frames into uart_rx_oversampled and
// scores received bytes and error strobes against a frame-level model.
module tb_uart_rx_oversampled;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 115200;
    localparam int BIT      = (CLK_FREQ + BAUD / 2) / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NBITS  = PAR_EN ? 11 : 10;
    localparam int LAT_LO = (NBITS - 1) * BIT + BIT / 4;
    localparam int LAT_HI = NBITS * BIT - BIT / 4;

    typedef struct packed {
        logic        ferr;
        logic        perr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_error;
    logic       RxD_parity_error;
    logic       RxD_idle;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   both_cnt = 0;
    int   orphan_perr = 0;
    logic [7:0] last_good = 8'h00;
    ev_t  exp_q[$];
    ev_t  got_q[$];

    uart_rx_oversampled #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .RxD(RxD),
        .RxD_data(RxD_data),
        .RxD_data_ready(RxD_data_ready),
        .RxD_frame_error(RxD_frame_error),
        .RxD_parity_error(RxD_parity_error),
        .RxD_idle(RxD_idle)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (RxD_data_ready || RxD_frame_error)
            got_q.push_back('{ferr: RxD_frame_error, perr: RxD_parity_error,
                              data: RxD_data, cyc: cyc});
        if (RxD_data_ready && RxD_frame_error) both_cnt <= both_cnt + 1;
        if (RxD_parity_error && !RxD_data_ready) orphan_perr <= orphan_perr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Model: stop=1 yields a ready event with the byte (parity error if the
    // parity bit disagrees with even parity); stop=0 yields a frame error
    // with RxD_data left at the last good byte.
    task automatic send_frame(input logic [7:0] b, input bit stop_v,
                              input bit par_v);
        ev_t e;
        bit  fr[$];
        if (stop_v) last_good = b;
        e.ferr = !stop_v;
        e.perr = PAR_EN && stop_v && (par_v != ^b);
        e.data = last_good;
        e.cyc  = cyc;
        exp_q.push_back(e);
        fr.push_back(1'b0);
        for (int i = 0; i < 8; i++) fr.push_back(b[i]);
        if (PAR_EN) fr.push_back(par_v);
        fr.push_back(stop_v);
        foreach (fr[i]) begin
            RxD = fr[i];
            repeat (BIT) @(negedge clk);
        end
        check("data_hold", RxD_data, last_good);
    endtask

    task automatic drain(input string tag);
        ev_t g;
        ev_t e;
        int  lat;
        repeat (BIT / 2) @(negedge clk);
        check({tag, ":count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            lat = int'(g.cyc) - int'(e.cyc);
            check({tag, ":ferr"}, g.ferr, e.ferr);
            check({tag, ":data"}, g.data, e.data);
            check({tag, ":perr"}, g.perr, e.perr);
            check({tag, ":lat"}, (lat >= LAT_LO && lat <= LAT_HI), 1);
        end
        got_q.delete();
        exp_q.delete();
        check({tag, ":idle"}, RxD_idle, 1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ":data"}, RxD_data, 8'h00);
        check({tag, ":ready"}, RxD_data_ready, 0);
        check({tag, ":ferr"}, RxD_frame_error, 0);
        check({tag, ":perr"}, RxD_parity_error, 0);
        check({tag, ":idle"}, RxD_idle, 1);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] v;
        bit         err;
        bit         par;
        RxD = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check_reset_outs("reset");
        repeat (BIT) @(negedge clk);

        send_frame(8'h97, 1'b1, ^8'h97);
        drain("f97");

        send_frame(8'h81, 1'b1, ^8'h81);
        send_frame(8'h00, 1'b1, 1'b0);
        drain("b2b");

        RxD = 1'b0;
        repeat (100) @(negedge clk);
        check("glitch_busy", RxD_idle, 0);
        repeat (8) @(negedge clk);
        RxD = 1'b1;
        repeat (242) @(negedge clk);
        check("glitch_back", RxD_idle, 1);
        drain("glitch");

        send_frame(8'h55, 1'b0, ^8'h55);
        repeat (29 * BIT) @(negedge clk);
        RxD = 1'b1;
        repeat (BIT) @(negedge clk);
        send_frame(8'hA5, 1'b1, ^8'hA5);
        drain("break");

        v = 8'h3C;
        RxD = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RxD = v[i];
            repeat (BIT) @(negedge clk);
        end
        RxD = v[4];
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outs("midrst");
        last_good = 8'h00;
        RxD = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        drain("midrst_quiet");
        send_frame(8'hC3, 1'b1, ^8'hC3);
        drain("after_rst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        drain("par_bad");
        send_frame(8'h07, 1'b1, 1'b1);
        drain("par_ok");
`endif

        for (int n = 0; n < 5; n++) begin
            b   = 8'($urandom);
            err = ($urandom_range(0, 3) == 0);
            par = ($urandom_range(0, 2) == 0) ? ~^b : ^b;
            send_frame(b, !err, par);
            if (err) begin
                repeat ($urandom_range(0, 3) * BIT) @(negedge clk);
                RxD = 1'b1;
                repeat (BIT) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 1) * BIT) @(negedge clk);
            end
        end
        drain("rand");

        check("ready_ferr_excl", both_cnt, 0);
        check("perr_alone", orphan_perr, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
